life_row_engine: RTL

- Computes one Game of Life next-generation row (X_SIZE cells) from three neighbouring current-generation rows (top, middle, bottom).
- Sits directly downstream of `line_buffer` and upstream of the results-line write port into the grid BRAMs.
- Processes CHUNK cells per cycle, holds the finished row behind a valid/ready handshake, and keeps a per-generation live-cell count.

---
 rtl/life_pkg.sv | 14 +
 rtl/life_cell_chunk.sv | 28 ++
 rtl/life_row_engine.sv | 112 +++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared sizes and state encoding for the Game of Life row engine.
package life_pkg;
  localparam int X_SIZE = 1280;
  localparam int Y_SIZE = 720;
  localparam int ROW_AW = 10;
  localparam int COL_AW = 11;
  localparam int POP_W  = 20;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    OUT  = 2'b10
  } state_t;
endpackage

// File: rtl/life_cell_chunk.sv
// Combinational Game of Life rule for CHUNK cells. Each input slice carries one
// extra column on either side, so bit i+1 of a slice is output cell i.
module life_cell_chunk #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK+1:0]               top,
  input  logic [CHUNK+1:0]               middle,
  input  logic [CHUNK+1:0]               bottom,
  output logic [CHUNK-1:0]               next_cells,
  output logic [$clog2(CHUNK + 1)-1:0]   pop
);
  localparam int CNT_W = $clog2(CHUNK + 1);

  logic [3:0] n;

  always_comb begin
    next_cells = '0;
    pop        = '0;
    n          = '0;
    for (int i = 0; i < CHUNK; i++) begin
      n = 4'(top[i]) + 4'(top[i+1]) + 4'(top[i+2])
        + 4'(middle[i]) + 4'(middle[i+2])
        + 4'(bottom[i]) + 4'(bottom[i+1]) + 4'(bottom[i+2]);
      next_cells[i] = (n == 4'd3) || (middle[i+1] && (n == 4'd2));
      pop = pop + CNT_W'(next_cells[i]);
    end
  end
endmodule

// File: rtl/life_row_engine.sv
// Computes one next-generation row CHUNK cells per cycle, holds it behind a
// valid/ready handshake and totals the live cells of each finished generation.
module life_row_engine import life_pkg::*; #(
  parameter int X_SIZE = life_pkg::X_SIZE,
  parameter int Y_SIZE = life_pkg::Y_SIZE,
  parameter int CHUNK  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROW_AW-1:0] in_row,
  input  logic [X_SIZE-1:0] top,
  input  logic [X_SIZE-1:0] middle,
  input  logic [X_SIZE-1:0] bottom,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_AW-1:0] out_row,
  output logic [X_SIZE-1:0] out_line,
  output logic              busy,
  output logic              frame_done,
  output logic [POP_W-1:0]  alive_count
);
  localparam int NCHUNK = X_SIZE / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = $clog2(X_SIZE + 2);
  localparam int CNT_W  = $clog2(CHUNK + 1);
  localparam logic [CW-1:0]     LAST_C   = CW'(NCHUNK - 1);
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(Y_SIZE - 1);

  if (X_SIZE % CHUNK != 0) begin : g_chunk_check
    $error("life_row_engine: X_SIZE must be a multiple of CHUNK");
  end

  state_t            state;
  logic [CW-1:0]     c;
  logic [X_SIZE-1:0] top_r, mid_r, bot_r;
  logic [COL_AW-1:0] row_pop;
  logic [POP_W-1:0]  frame_acc;
  logic [X_SIZE+1:0] top_pad, mid_pad, bot_pad;
  logic [IW-1:0]     base;
  logic [CHUNK-1:0]  chunk_next;
  logic [CNT_W-1:0]  chunk_pop;

  // Zero padding on both ends gives the dead columns beyond the grid edges.
  assign top_pad = {1'b0, top_r, 1'b0};
  assign mid_pad = {1'b0, mid_r, 1'b0};
  assign bot_pad = {1'b0, bot_r, 1'b0};
  assign base    = IW'(c * CHUNK);

  life_cell_chunk #(.CHUNK(CHUNK)) u_cells (
    .top        (top_pad[base +: CHUNK+2]),
    .middle     (mid_pad[base +: CHUNK+2]),
    .bottom     (bot_pad[base +: CHUNK+2]),
    .next_cells (chunk_next),
    .pop        (chunk_pop)
  );

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (reset) begin
      state       <= IDLE;
      c           <= '0;
      top_r       <= '0;
      mid_r       <= '0;
      bot_r       <= '0;
      row_pop     <= '0;
      frame_acc   <= '0;
      alive_count <= '0;
      out_line    <= '0;
      out_row     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            top_r   <= top;
            mid_r   <= middle;
            bot_r   <= bottom;
            out_row <= in_row;
            c       <= '0;
            row_pop <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          out_line[base +: CHUNK] <= chunk_next;
          row_pop <= row_pop + COL_AW'(chunk_pop);
          if (c == LAST_C) state <= OUT;
          else             c     <= c + 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            // Only the last row of the grid closes a generation.
            if (out_row == LAST_ROW) begin
              alive_count <= frame_acc + POP_W'(row_pop);
              frame_acc   <= '0;
              frame_done  <= 1'b1;
            end else begin
              frame_acc <= frame_acc + POP_W'(row_pop);
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
